sawtooth_seq_ctrl: RTL and testbench
====================================

// Module: sawtooth_seq_ctrl
// PURPOSE
//  Front-end sequencer for the sawtooth counter datapath; sits between the board
//  push-buttons/switches and the counter core. Conditions the active-low v/ST buttons,
//  captures N1 then N2 from din_i on successive v presses, validates N1<N2, then
//  starts, pauses and resumes the counter core. Also counts completed sawtooth periods.
// PARAMETERS
//  DW           8        data width of din_i, n1_o, n2_o
//  DEB_CYCLES   1000000  consecutive low clk samples required to accept a press (>=2)
//  PCNT_W       8        width of period_cnt_o
// PORTS
//  clk_i         in   1       system clock
//  rst_i         in   1       reset, asynchronous, active-low
//  v_i           in   1       "value/switch" button, active-low, asynchronous to clk_i
//  ST_i          in   1       start/stop button, active-low, asynchronous to clk_i
//  din_i         in   DW      data switches
//  wrap_i        in   1       1-cycle pulse from counter core: one period completed
//  n1_o          out  DW      captured lower bound
//  n2_o          out  DW      captured upper bound
//  run_o         out  1       counter core enable
//  clr_o         out  1       1-cycle pulse: reload counter core from n1_o
//  err_o         out  1       parameter error (N1>=N2), held until next v press
//  state_o       out  3       current state encoding (debug/sseg)
//  period_cnt_o  out  PCNT_W  completed periods since last clr_o, saturating
// BEHAVIOUR
//  Reset (rst_i=0, async): state IDLE; n1_o=n2_o=0; run_o=clr_o=err_o=0; period_cnt_o=0.
//  Button path: 2-FF sync -> debounce counter -> press pulse (v_evt/st_evt, 1 clk).
//   - Pulse fires once, DEB_CYCLES+2 clks after the first low edge reaches the pin, if
//     the pin stays low throughout. Any high sample restarts the count.
//   - No further pulse until DEB_CYCLES consecutive high samples (release).
//   - din_i passes through the same 2-FF delay. Value captured = synced din on the
//     v_evt cycle.
//  States (state_o): IDLE=0 LOAD_N1=1 LOAD_N2=2 READY=3 RUN=4 PAUSE=5 ERR=6.
//   IDLE    --v_evt--> LOAD_N1 (err_o<=0)
//   LOAD_N1 --v_evt--> LOAD_N2, n1_o<=din
//   LOAD_N2 --v_evt--> n2_o<=din. If n1_o<din: READY, clr_o pulse. Otherwise: ERR, err_o<=1.
//   READY   --st_evt--> RUN, run_o<=1.   --v_evt--> LOAD_N1
//   RUN     --st_evt--> PAUSE, run_o<=0. v_evt ignored.
//   PAUSE   --st_evt--> RUN (no clr, resume).   --v_evt--> LOAD_N1, clr_o pulse
//   ERR     --v_evt--> LOAD_N1, err_o<=0. st_evt ignored.
//   st_evt in IDLE/LOAD_N1/LOAD_N2 ignored.
//  Output timing:
//   - All outputs registered; transition effects are visible the clk after the event pulse.
//   - run_o==1 iff state==RUN.
//  Simultaneous v_evt and st_evt: v_evt wins in every state except RUN, where st_evt is
//   taken and v_evt is dropped.
//  Period counter:
//   - Increments on wrap_i only while run_o=1; saturates at 2^PCNT_W-1.
//   - Cleared on clr_o. If clr_o and wrap_i coincide, the clear wins.
//  Comparison is unsigned, full DW. N1==N2 is an error.
//  Reset mid-operation returns to IDLE on the next rst_i assertion and aborts any
//   in-progress debounce.
// STRUCTURE
//  Package sawtooth_pkg:
//   - typedef enum logic[2:0] seq_state_t (encodings above)
//   - localparam DEB_CYCLES_DEF
//  Sub-module btn_conditioner, instantiated for v_i and ST_i:
//   - 2-FF sync, debounce counter, press pulse
//   - params DEB_CYCLES; ports clk_i, rst_i, btn_i, press_o
//  Top: FSM, capture registers, period counter.
// TESTING  (bench overrides DEB_CYCLES=4)
//  1 rst_i low 5 clk -> all outputs 0, state_o=0. Glitch v_i low for 2 clk -> no transition.
//  2 v press; v press with din=20; v press with din=40 -> n1_o=20, n2_o=40, state_o=3,
//    clr_o single pulse.
//  3 From READY: ST -> run_o=1. 3 wrap_i pulses -> period_cnt_o=3. ST -> run_o=0, state 5.
//    ST -> run_o=1, count still 3.
//  4 Load din=76 then din=15 -> state_o=6, err_o=1. ST press -> no change.
//    v press -> state 1, err_o=0.
//  5 In RUN: press v and ST in the same clk -> state 5 (PAUSE), v ignored.
//    Hold v_i low 20 clk -> exactly one v_evt.
//  6 Assert rst_i while RUN with period_cnt_o=5 -> immediate IDLE, run_o=0, count 0.

Source files
------------

// File: rtl/sawtooth_seq_ctrl_pkg.sv
// Shared types and defaults for the sawtooth counter front-end sequencer.
package sawtooth_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_N1 = 3'd1,
      S_LOAD_N2 = 3'd2,
      S_READY   = 3'd3,
      S_RUN     = 3'd4,
      S_PAUSE   = 3'd5,
      S_ERR     = 3'd6
   } seq_state_t;

   localparam int DEB_CYCLES_DEF = 1000000;

endpackage

// File: rtl/sawtooth_seq_ctrl_btn_conditioner.sv
// Active-low push-button conditioner: 2-FF synchronizer, debounce down-counter,
// one-clock press pulse on an accepted high-to-low transition.
module btn_conditioner #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;
   logic [CW-1:0] cnt;

   // level is the debounced button state; it flips only after DEB_CYCLES
   // consecutive synced samples disagree with it.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync_1  <= 1'b1;
         sync_2  <= 1'b1;
         level   <= 1'b1;
         cnt     <= CNT_LOAD;
         press_o <= 1'b0;
      end else begin
         sync_1  <= btn_i;
         sync_2  <= sync_1;
         press_o <= 1'b0;
         if (sync_2 != level) begin
            if (cnt == '0) begin
               level   <= sync_2;
               cnt     <= CNT_LOAD;
               press_o <= level;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end else begin
            cnt <= CNT_LOAD;
         end
      end
   end

endmodule

// File: rtl/sawtooth_seq_ctrl.sv
// Sawtooth counter front-end: button conditioning, N1/N2 capture and
// validation, run/pause control of the counter core, completed-period count.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  S_IDLE    | after reset, waiting for first v press
//  S_LOAD_N1 | next v press captures N1
//  S_LOAD_N2 | next v press captures N2 and validates N1<N2
//  S_READY   | bounds valid, core reloaded, waiting for ST
//  S_RUN     | core enabled
//  S_PAUSE   | core held, ST resumes, v restarts loading
//  S_ERR     | N1>=N2, waiting for v to restart loading
module sawtooth_seq_ctrl
   import sawtooth_pkg::*;
#(
   parameter int DW         = 8,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int PCNT_W     = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              v_i,
   input  logic              ST_i,
   input  logic [DW-1:0]     din_i,
   input  logic              wrap_i,
   output logic [DW-1:0]     n1_o,
   output logic [DW-1:0]     n2_o,
   output logic              run_o,
   output logic              clr_o,
   output logic              err_o,
   output logic [2:0]        state_o,
   output logic [PCNT_W-1:0] period_cnt_o
);

   seq_state_t    state;
   logic          v_evt;
   logic          st_evt;
   logic [DW-1:0] din_s1;
   logic [DW-1:0] din_s2;

   btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_v_btn (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (v_i),
      .press_o (v_evt)
   );

   btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_st_btn (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (ST_i),
      .press_o (st_evt)
   );

   // Same 2-FF latency as the button path, so the captured value matches
   // what the switches showed when the press was sampled.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         din_s1 <= '0;
         din_s2 <= '0;
      end else begin
         din_s1 <= din_i;
         din_s2 <= din_s1;
      end
   end

   assign state_o = state;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= S_IDLE;
         n1_o  <= '0;
         n2_o  <= '0;
         run_o <= 1'b0;
         clr_o <= 1'b0;
         err_o <= 1'b0;
      end else begin
         clr_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (v_evt) begin
                  state <= S_LOAD_N1;
                  err_o <= 1'b0;
               end
            end
            S_LOAD_N1: begin
               if (v_evt) begin
                  state <= S_LOAD_N2;
                  n1_o  <= din_s2;
               end
            end
            S_LOAD_N2: begin
               if (v_evt) begin
                  n2_o <= din_s2;
                  if (n1_o < din_s2) begin
                     state <= S_READY;
                     clr_o <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     err_o <= 1'b1;
                  end
               end
            end
            S_READY: begin
               if (v_evt) begin
                  state <= S_LOAD_N1;
               end else if (st_evt) begin
                  state <= S_RUN;
                  run_o <= 1'b1;
               end
            end
            S_RUN: begin
               if (st_evt) begin
                  state <= S_PAUSE;
                  run_o <= 1'b0;
               end
            end
            S_PAUSE: begin
               if (v_evt) begin
                  state <= S_LOAD_N1;
                  clr_o <= 1'b1;
               end else if (st_evt) begin
                  state <= S_RUN;
                  run_o <= 1'b1;
               end
            end
            S_ERR: begin
               if (v_evt) begin
                  state <= S_LOAD_N1;
                  err_o <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               run_o <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         period_cnt_o <= '0;
      end else if (clr_o) begin
         period_cnt_o <= '0;
      end else if (wrap_i && run_o && (period_cnt_o != '1)) begin
         period_cnt_o <= period_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_sawtooth_seq_ctrl.sv
// Directed bench for sawtooth_seq_ctrl with a short debounce window.
module tb_sawtooth_seq_ctrl;

   logic       clk_i;
   logic       rst_i;
   logic       v_i;
   logic       ST_i;
   logic [7:0] din_i;
   logic       wrap_i;
   logic [7:0] n1_o;
   logic [7:0] n2_o;
   logic       run_o;
   logic       clr_o;
   logic       err_o;
   logic [2:0] state_o;
   logic [7:0] period_cnt_o;

   int checks   = 0;
   int failures = 0;
   int clr_cnt  = 0;

   sawtooth_seq_ctrl #(.DW(8), .DEB_CYCLES(4), .PCNT_W(8)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .v_i          (v_i),
      .ST_i         (ST_i),
      .din_i        (din_i),
      .wrap_i       (wrap_i),
      .n1_o         (n1_o),
      .n2_o         (n2_o),
      .run_o        (run_o),
      .clr_o        (clr_o),
      .err_o        (err_o),
      .state_o      (state_o),
      .period_cnt_o (period_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (rst_i && clr_o) clr_cnt++;
   end

   typedef struct {
      logic       v;
      logic       st;
      logic [7:0] din;
      int         wraps;
      logic [2:0] e_state;
      logic [7:0] e_n1;
      logic [7:0] e_n2;
      logic       e_run;
      logic       e_err;
      logic [7:0] e_pcnt;
      int         e_clr;
   } vec_t;

   vec_t vecs[24];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic press(input logic v, input logic st, input logic [7:0] din, input int hold);
      @(negedge clk_i);
      din_i = din;
      v_i   = ~v;
      ST_i  = ~st;
      repeat (hold) @(negedge clk_i);
      v_i  = 1'b1;
      ST_i = 1'b1;
      repeat (10) @(negedge clk_i);
   endtask

   task automatic do_wraps(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_i);
         wrap_i = 1'b1;
         @(negedge clk_i);
         wrap_i = 1'b0;
      end
   endtask

   task automatic check_all(input string tag, input int s, input int n1, input int n2,
                            input int run, input int err, input int pcnt);
      check({tag, " state"}, int'(state_o), s);
      check({tag, " n1"}, int'(n1_o), n1);
      check({tag, " n2"}, int'(n2_o), n2);
      check({tag, " run"}, int'(run_o), run);
      check({tag, " err"}, int'(err_o), err);
      check({tag, " pcnt"}, int'(period_cnt_o), pcnt);
   endtask

   initial begin
      //            v    st   din    wr  st  n1   n2   run  err pcnt clr
      vecs[0]  = '{1'b1, 1'b0, 8'd0,   0, 1, 0,   0,   1'b0, 1'b0, 0, 0};
      vecs[1]  = '{1'b1, 1'b0, 8'd20,  0, 2, 20,  0,   1'b0, 1'b0, 0, 0};
      vecs[2]  = '{1'b1, 1'b0, 8'd40,  0, 3, 20,  40,  1'b0, 1'b0, 0, 1};
      vecs[3]  = '{1'b0, 1'b1, 8'd0,   0, 4, 20,  40,  1'b1, 1'b0, 0, 1};
      vecs[4]  = '{1'b0, 1'b0, 8'd0,   3, 4, 20,  40,  1'b1, 1'b0, 3, 1};
      vecs[5]  = '{1'b0, 1'b1, 8'd0,   0, 5, 20,  40,  1'b0, 1'b0, 3, 1};
      vecs[6]  = '{1'b0, 1'b0, 8'd0,   2, 5, 20,  40,  1'b0, 1'b0, 3, 1};
      vecs[7]  = '{1'b0, 1'b1, 8'd0,   0, 4, 20,  40,  1'b1, 1'b0, 3, 1};
      vecs[8]  = '{1'b0, 1'b1, 8'd0,   0, 5, 20,  40,  1'b0, 1'b0, 3, 1};
      vecs[9]  = '{1'b1, 1'b0, 8'd76,  0, 1, 20,  40,  1'b0, 1'b0, 0, 2};
      vecs[10] = '{1'b1, 1'b0, 8'd76,  0, 2, 76,  40,  1'b0, 1'b0, 0, 2};
      vecs[11] = '{1'b1, 1'b0, 8'd15,  0, 6, 76,  15,  1'b0, 1'b1, 0, 2};
      vecs[12] = '{1'b0, 1'b1, 8'd0,   0, 6, 76,  15,  1'b0, 1'b1, 0, 2};
      vecs[13] = '{1'b1, 1'b0, 8'd0,   0, 1, 76,  15,  1'b0, 1'b0, 0, 2};
      vecs[14] = '{1'b1, 1'b0, 8'd50,  0, 2, 50,  15,  1'b0, 1'b0, 0, 2};
      vecs[15] = '{1'b1, 1'b0, 8'd50,  0, 6, 50,  50,  1'b0, 1'b1, 0, 2};
      vecs[16] = '{1'b1, 1'b0, 8'd0,   0, 1, 50,  50,  1'b0, 1'b0, 0, 2};
      vecs[17] = '{1'b1, 1'b0, 8'd10,  0, 2, 10,  50,  1'b0, 1'b0, 0, 2};
      vecs[18] = '{1'b1, 1'b0, 8'd200, 0, 3, 10,  200, 1'b0, 1'b0, 0, 3};
      vecs[19] = '{1'b1, 1'b1, 8'd0,   0, 1, 10,  200, 1'b0, 1'b0, 0, 3};
      vecs[20] = '{1'b1, 1'b0, 8'd10,  0, 2, 10,  200, 1'b0, 1'b0, 0, 3};
      vecs[21] = '{1'b1, 1'b0, 8'd255, 0, 3, 10,  255, 1'b0, 1'b0, 0, 4};
      vecs[22] = '{1'b0, 1'b1, 8'd0,   0, 4, 10,  255, 1'b1, 1'b0, 0, 4};
      vecs[23] = '{1'b0, 1'b0, 8'd0,   5, 4, 10,  255, 1'b1, 1'b0, 5, 4};

      rst_i  = 1'b0;
      v_i    = 1'b1;
      ST_i   = 1'b1;
      din_i  = 8'd0;
      wrap_i = 1'b0;
      repeat (5) @(negedge clk_i);
      check_all("reset", 0, 0, 0, 0, 0, 0);
      check("reset clr", int'(clr_o), 0);
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);

      v_i = 1'b0;
      repeat (2) @(negedge clk_i);
      v_i = 1'b1;
      repeat (12) @(negedge clk_i);
      check("glitch state", int'(state_o), 0);

      for (int i = 0; i < 24; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         if (vecs[i].v || vecs[i].st) press(vecs[i].v, vecs[i].st, vecs[i].din, 10);
         if (vecs[i].wraps > 0) do_wraps(vecs[i].wraps);
         repeat (2) @(negedge clk_i);
         check_all(tag, vecs[i].e_state, vecs[i].e_n1, vecs[i].e_n2,
                   vecs[i].e_run, vecs[i].e_err, vecs[i].e_pcnt);
         check({tag, " clr_pulses"}, clr_cnt, vecs[i].e_clr);
      end

      // v and ST together while running: ST is taken, v dropped
      press(1'b1, 1'b1, 8'd99, 10);
      check_all("simul_run", 5, 10, 255, 0, 0, 5);

      // long v hold from PAUSE must yield a single event
      press(1'b1, 1'b0, 8'd0, 20);
      check("long_hold state", int'(state_o), 1);
      check("long_hold clr", clr_cnt, 5);
      check("long_hold pcnt", int'(period_cnt_o), 0);

      press(1'b1, 1'b0, 8'd10, 10);
      press(1'b1, 1'b0, 8'd200, 10);
      press(1'b0, 1'b1, 8'd0, 10);
      do_wraps(5);
      @(negedge clk_i);
      check_all("pre_rst", 4, 10, 200, 1, 0, 5);

      rst_i = 1'b0;
      #1;
      check_all("mid_rst", 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);

      press(1'b1, 1'b0, 8'd0, 10);
      press(1'b1, 1'b0, 8'd10, 10);
      press(1'b1, 1'b0, 8'd200, 10);
      press(1'b0, 1'b1, 8'd0, 10);
      do_wraps(260);
      @(negedge clk_i);
      check("saturate pcnt", int'(period_cnt_o), 255);
      check("saturate state", int'(state_o), 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
